display: RTL and testbench
==========================

DISPLAY -- requirements
Module: display

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning the number of clk cycles each digit stays lit (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low: rst=0 resets immediately, release is sampled on clk.
REQ-004 data  input  16  four hex digits; data[3:0] is digit 0 (rightmost) and data[15:12] is digit 3 (leftmost).
REQ-005 sm_wei  output  4  digit enables, active-low, at most one bit low; bit k drives digit k.
REQ-006 sm_duan  output  7  segment drives, active-low, bit order {g,f,e,d,c,b,a} = sm_duan[6:0].

Function
REQ-007 The block SHALL contain a scan counter of width ceil(log2(SCAN_DIV)) that counts 0..SCAN_DIV-1 and then wraps to 0.
REQ-008 The block SHALL contain a 2-bit digit index. The index increments, modulo 4, in the cycle where the scan counter wraps; the index wraps 3->0.
REQ-009 sm_wei and sm_duan SHALL be registered outputs: each cycle, sm_wei <= ~(4'b0001 << idx) and sm_duan <= SEG(data[4*idx+3 -: 4]).
REQ-010 Outputs SHALL lag the index and data inputs by exactly 1 clk. A change on data SHALL appear on sm_duan 1 cycle later, provided that nibble is the selected digit.
REQ-011 SEG SHALL map hex values as follows, active-low {g..a}:
 - 0=1000000, 1=1111001, 2=0100100, 3=0110000
 - 4=0011001, 5=0010010, 6=0000010, 7=1111000
 - 8=0000000, 9=0010000, A=0001000, b=0000011
 - C=1000110, d=0100001, E=0000110, F=0001110
REQ-012 SEG SHALL map any nibble containing an X or Z bit to 1111111 (blank); this applies in simulation only.
REQ-013 The scan order SHALL be digit 0, 1, 2, 3, 0, ...; each digit SHALL be enabled for exactly SCAN_DIV consecutive cycles.
REQ-014 The block SHALL never drive more than one sm_wei bit low in the same cycle, including at transitions.
REQ-015 The data input SHALL be sampled every cycle, with no latching; all 16 bits may change at any time.
REQ-016 The block SHALL have no other outputs and no handshake; it is free-running.

Reset
REQ-017 While rst=0, the block SHALL hold:
 - scan counter = 0 and idx = 0
 - sm_wei = 4'b1111 (all digits off)
 - sm_duan = 7'b1111111 (all segments off)
REQ-018 On the first rising clk edge after rst goes high, the outputs SHALL become sm_wei = 4'b1110 and sm_duan = SEG(data[3:0]).
REQ-019 Asserting rst in the middle of a scan SHALL immediately force the REQ-017 values; after release, scanning SHALL restart at digit 0 with a full SCAN_DIV dwell.

Verification (SCAN_DIV=4 for simulation)
REQ-020 Scenario: hold rst=0 for 3 cycles with data=16'h1234 -> sm_wei=1111 and sm_duan=1111111 throughout; release -> next edge gives sm_wei=1110, sm_duan=0011001 ("4").
REQ-021 Scenario: data=16'h1234, run 16 cycles after reset -> the digit sequence is 1110/"4", 1101/"3", 1011/"2", 0111/"1", each held 4 cycles, then it wraps to 1110.
REQ-022 Scenario: drive data over 0x0..0xF on all nibbles -> every sm_duan value matches the REQ-011 table for every digit position.
REQ-023 Scenario: while digit 2 is active, change data from 16'h0000 to 16'h0A00 -> sm_duan goes from 1000000 to 0001000 one cycle later.
REQ-024 Scenario: pulse rst=0 asynchronously between clk edges during digit 3 -> outputs blank immediately, without waiting for a clock edge; after release, digit 0 is shown for the full 4 cycles.
REQ-025 Scenario: run 1000 cycles with random data -> every cycle, sm_wei is all-ones or has exactly one zero bit.

Source files
------------

// File: rtl/display.sv
// Four-digit multiplexed seven-segment driver. Each digit is lit for SCAN_DIV
// cycles in turn (0,1,2,3,...). Enables and segments are registered and active-low.
module display #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data,
   output logic [3:0]  sm_wei,
   output logic [6:0]  sm_duan
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       wei_q, wei_d;
   logic [6:0]       duan_q, duan_d;
   logic [3:0]       nibble;
   logic             wrap;

   // Case without wildcards: a nibble with X/Z bits matches no item and blanks.
   function automatic logic [6:0] seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      wrap   = (cnt_q == CNT_MAX);
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d  = wrap ? idx_q + 2'd1 : idx_q;
      nibble = data[{idx_q, 2'b00} +: 4];
      // Enable is decoded from a single index, so at most one bit is ever low.
      wei_d  = ~(4'b0001 << idx_q);
      duan_d = seg(nibble);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         idx_q  <= 2'd0;
         wei_q  <= 4'b1111;
         duan_q <= 7'b1111111;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         wei_q  <= wei_d;
         duan_q <= duan_d;
      end
   end

   assign sm_wei  = wei_q;
   assign sm_duan = duan_q;

endmodule

// File: tb/tb_display.sv
// Directed bench for display with SCAN_DIV=4: reset, scan order, segment table,
// live data update, asynchronous reset and a random one-hot-low sweep.
module tb_display;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] data = 16'h0000;
   logic [3:0]  sm_wei;
   logic [6:0]  sm_duan;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0] seg_tab [16];
   logic [3:0] wei_tab [4];

   display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .data    (data),
      .sm_wei  (sm_wei),
      .sm_duan (sm_duan)
   );

   always #5 clk = ~clk;

   // After this returns, the next negedge shows cycle 1 of digit 0.
   task automatic do_reset(input logic [15:0] d);
      @(negedge clk);
      rst  = 1'b0;
      data = d;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst  = 1'b0;
      data = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (sm_wei !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_wei cycle %0d: got %b expected 1111", i, sm_wei);
         end
         vectors++;
         if (sm_duan !== 7'b1111111) begin
            miscompares++;
            $display("FAIL reset_duan cycle %0d: got %b expected 1111111", i, sm_duan);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (sm_wei !== 4'b1110 || sm_duan !== 7'b0011001) begin
         miscompares++;
         $display("FAIL reset_release: got %b/%b expected 1110/0011001", sm_wei, sm_duan);
      end
   endtask

   task automatic test_scan_order();
      int d;
      do_reset(16'h1234);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         d = ((k - 1) / 4) % 4;
         vectors++;
         if (sm_wei !== wei_tab[d] || sm_duan !== seg_tab[4 - d]) begin
            miscompares++;
            $display("FAIL scan_order cycle %0d: got %b/%b expected %b/%b",
                     k, sm_wei, sm_duan, wei_tab[d], seg_tab[4 - d]);
         end
      end
   endtask

   task automatic test_seg_table();
      do_reset(16'h0000);
      for (int v = 0; v < 16; v++) begin
         data = {4{v[3:0]}};
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vectors++;
            if (sm_duan !== seg_tab[v]) begin
               miscompares++;
               $display("FAIL seg_table value %0h cycle %0d: got %b expected %b",
                        v, c, sm_duan, seg_tab[v]);
            end
         end
      end
   endtask

   task automatic test_data_change();
      do_reset(16'h0000);
      for (int k = 1; k <= 9; k++) @(negedge clk);
      vectors++;
      if (sm_wei !== 4'b1011 || sm_duan !== 7'b1000000) begin
         miscompares++;
         $display("FAIL data_change_before: got %b/%b expected 1011/1000000", sm_wei, sm_duan);
      end
      data = 16'h0A00;
      @(negedge clk);
      vectors++;
      if (sm_wei !== 4'b1011 || sm_duan !== 7'b0001000) begin
         miscompares++;
         $display("FAIL data_change_after: got %b/%b expected 1011/0001000", sm_wei, sm_duan);
      end
   endtask

   task automatic test_async_reset();
      do_reset(16'h1234);
      for (int k = 1; k <= 14; k++) @(negedge clk);
      vectors++;
      if (sm_wei !== 4'b0111 || sm_duan !== 7'b1111001) begin
         miscompares++;
         $display("FAIL async_pre: got %b/%b expected 0111/1111001", sm_wei, sm_duan);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (sm_wei !== 4'b1111 || sm_duan !== 7'b1111111) begin
         miscompares++;
         $display("FAIL async_immediate: got %b/%b expected 1111/1111111", sm_wei, sm_duan);
      end
      @(negedge clk);
      vectors++;
      if (sm_wei !== 4'b1111 || sm_duan !== 7'b1111111) begin
         miscompares++;
         $display("FAIL async_hold: got %b/%b expected 1111/1111111", sm_wei, sm_duan);
      end
      rst = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         vectors++;
         if (k <= 4 && (sm_wei !== 4'b1110 || sm_duan !== 7'b0011001)) begin
            miscompares++;
            $display("FAIL async_restart cycle %0d: got %b/%b expected 1110/0011001",
                     k, sm_wei, sm_duan);
         end else if (k == 5 && (sm_wei !== 4'b1101 || sm_duan !== 7'b0110000)) begin
            miscompares++;
            $display("FAIL async_restart cycle 5: got %b/%b expected 1101/0110000",
                     sm_wei, sm_duan);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] cur;
      logic [3:0]  nib;
      int          d;
      cur = 16'($urandom);
      do_reset(cur);
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         vectors++;
         if ($countones(~sm_wei) > 1) begin
            miscompares++;
            $display("FAIL random_onehot cycle %0d: got %b expected at most one zero", k, sm_wei);
         end
         d   = ((k - 1) / 4) % 4;
         nib = cur[4*d +: 4];
         vectors++;
         if (sm_wei !== wei_tab[d] || sm_duan !== seg_tab[nib]) begin
            miscompares++;
            $display("FAIL random_digit cycle %0d: got %b/%b expected %b/%b",
                     k, sm_wei, sm_duan, wei_tab[d], seg_tab[nib]);
         end
         cur  = 16'($urandom_range(0, 65535));
         data = cur;
      end
   endtask

   initial begin
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
      wei_tab[0]  = 4'b1110;    wei_tab[1]  = 4'b1101;
      wei_tab[2]  = 4'b1011;    wei_tab[3]  = 4'b0111;

      test_reset();
      test_scan_order();
      test_seg_table();
      test_data_change();
      test_async_reset();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
